rram_instr_arbiter: RTL and testbench

Merges the two instruction FIFOs (external host stream and HD-engine stream) into one instruction stream for the RRAM crossbar controller. It arbitrates between the sources round-robin, pops the winning FIFO and holds the word in a one-entry output register. The register is handed to the controller over a valid/ready handshake. The block sits between the instruction FIFOs and the controller's instruction decoder in the per-core top level.

---
 rtl/rram_ctrl_pkg.sv | 23 ++
 rtl/rram_rr_arb2.sv | 47 ++++
 rtl/rram_instr_arbiter.sv | 110 +++++++++++
 tb/tb_rram_instr_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rram_ctrl_pkg.sv
// Shared types and widths for the RRAM crossbar controller instruction path.
// Used by the instruction arbiter and the controller's instruction decoder.
package rram_ctrl_pkg;

    localparam int unsigned INSTR_CLS_W = 4;
    localparam int unsigned INSTR_OP_W  = 16;
    localparam int unsigned INSTR_W     = INSTR_CLS_W + INSTR_OP_W;

    typedef enum logic {
        SRC_EXT = 1'b0,
        SRC_HD  = 1'b1
    } instr_src_t;

    // Class in the upper bits, opcode/operand in the lower bits.
    typedef struct packed {
        logic [INSTR_CLS_W-1:0] cls;
        logic [INSTR_OP_W-1:0]  opcode;
    } instr_word_t;

    localparam int unsigned REQ_EXT = 0;
    localparam int unsigned REQ_HD  = 1;

endpackage

// File: rtl/rram_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last wins.
// Grants only while adv_i is high, and only a grant moves the last-grant pointer.
module rram_rr_arb2
    import rram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    instr_src_t last_q, last_d;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        gnt_o = 2'b00;
        if (adv_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (last_q == SRC_HD) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_o[REQ_HD]) begin
            last_d = SRC_HD;
        end else if (gnt_o[REQ_EXT]) begin
            last_d = SRC_EXT;
        end
    end

    // Reset to hd so the first tie after reset goes to ext.
    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= SRC_HD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rram_instr_arbiter.sv
// Merges the ext and hd instruction FIFOs into one valid/ready stream for the
// crossbar controller: round-robin pop, one-entry output register, issue counters.
module rram_instr_arbiter
    import rram_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH  = INSTR_CLS_W,
    parameter int unsigned OPCODE_WIDTH = INSTR_OP_W,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                                CLK,
    input  logic                                rst_n,
    input  logic                                empty_instFIFO_ext,
    input  logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] dout_instFIFO_ext,
    output logic                                pop_n_instFIFO_ext,
    input  logic                                empty_instFIFO_hd,
    input  logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] dout_instFIFO_hd,
    output logic                                pop_n_instFIFO_hd,
    input  logic                                hd_en,
    input  logic                                halt,
    output logic                                instr_valid,
    input  logic                                instr_ready,
    output logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] instr_data,
    output logic                                instr_src,
    output logic [CNT_WIDTH-1:0]                issue_cnt_ext,
    output logic [CNT_WIDTH-1:0]                issue_cnt_hd
);

    localparam int unsigned W = INSTR_WIDTH + OPCODE_WIDTH;

    logic [1:0]           req;
    logic [1:0]           gnt;
    logic                 can_load;
    logic                 accept;

    logic                 valid_q, valid_d;
    logic [W-1:0]         data_q, data_d;
    instr_src_t           src_q, src_d;
    logic [CNT_WIDTH-1:0] cnt_ext_q, cnt_ext_d;
    logic [CNT_WIDTH-1:0] cnt_hd_q, cnt_hd_d;

    assign req[REQ_EXT] = !empty_instFIFO_ext;
    assign req[REQ_HD]  = !empty_instFIFO_hd && hd_en;

    // rst_n gates the grant: a pop taken while in reset would be lost with the cleared register.
    assign can_load = rst_n && !halt && (!valid_q || instr_ready);
    assign accept   = valid_q && instr_ready;

    rram_rr_arb2 u_arb (
        .clk   (CLK),
        .rst_n (rst_n),
        .req_i (req),
        .adv_i (can_load),
        .gnt_o (gnt)
    );

    assign pop_n_instFIFO_ext = !gnt[REQ_EXT];
    assign pop_n_instFIFO_hd  = !gnt[REQ_HD];

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        if (gnt[REQ_HD]) begin
            valid_d = 1'b1;
            data_d  = dout_instFIFO_hd;
            src_d   = SRC_HD;
        end else if (gnt[REQ_EXT]) begin
            valid_d = 1'b1;
            data_d  = dout_instFIFO_ext;
            src_d   = SRC_EXT;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        cnt_ext_d = cnt_ext_q;
        cnt_hd_d  = cnt_hd_q;
        if (accept && (src_q == SRC_EXT) && (cnt_ext_q != '1)) begin
            cnt_ext_d = cnt_ext_q + CNT_WIDTH'(1);
        end
        if (accept && (src_q == SRC_HD) && (cnt_hd_q != '1)) begin
            cnt_hd_d = cnt_hd_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            src_q     <= SRC_EXT;
            cnt_ext_q <= '0;
            cnt_hd_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            src_q     <= src_d;
            cnt_ext_q <= cnt_ext_d;
            cnt_hd_q  <= cnt_hd_d;
        end
    end

    assign instr_valid   = valid_q;
    assign instr_data    = data_q;
    assign instr_src     = src_q;
    assign issue_cnt_ext = cnt_ext_q;
    assign issue_cnt_hd  = cnt_hd_q;

endmodule

// File: tb/tb_rram_instr_arbiter.sv
// Directed bench for rram_instr_arbiter: FWFT FIFO models driven from queues,
// issued words logged on each handshake and compared to hand-computed orders.
module tb_rram_instr_arbiter;

    localparam int unsigned W = 20;

    logic         CLK = 1'b0;
    logic         rst_n;
    logic         empty_instFIFO_ext, empty_instFIFO_hd;
    logic [W-1:0] dout_instFIFO_ext, dout_instFIFO_hd;
    logic         pop_n_instFIFO_ext, pop_n_instFIFO_hd;
    logic         hd_en, halt;
    logic         instr_valid, instr_ready;
    logic [W-1:0] instr_data;
    logic         instr_src;
    logic [15:0]  issue_cnt_ext, issue_cnt_hd;

    logic [W-1:0] ext_q[$];
    logic [W-1:0] hd_q[$];
    logic [W:0]   issued[$];
    int           n_tests = 0;
    int           n_fail = 0;
    int           dbl_pop = 0;
    int           empty_pop = 0;

    always #5 CLK = ~CLK;

    rram_instr_arbiter #(
        .INSTR_WIDTH  (4),
        .OPCODE_WIDTH (16),
        .CNT_WIDTH    (16)
    ) dut (
        .CLK                (CLK),
        .rst_n              (rst_n),
        .empty_instFIFO_ext (empty_instFIFO_ext),
        .dout_instFIFO_ext  (dout_instFIFO_ext),
        .pop_n_instFIFO_ext (pop_n_instFIFO_ext),
        .empty_instFIFO_hd  (empty_instFIFO_hd),
        .dout_instFIFO_hd   (dout_instFIFO_hd),
        .pop_n_instFIFO_hd  (pop_n_instFIFO_hd),
        .hd_en              (hd_en),
        .halt               (halt),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .instr_data         (instr_data),
        .instr_src          (instr_src),
        .issue_cnt_ext      (issue_cnt_ext),
        .issue_cnt_hd       (issue_cnt_hd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        empty_instFIFO_ext = (ext_q.size() == 0);
        empty_instFIFO_hd  = (hd_q.size() == 0);
        dout_instFIFO_ext  = (ext_q.size() != 0) ? ext_q[0] : '0;
        dout_instFIFO_hd   = (hd_q.size() != 0) ? hd_q[0] : '0;
    endtask

    task automatic settle();
        #1;
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic cycle();
        logic       pe, ph, acc;
        logic [W:0] word;
        #1;
        pe   = pop_n_instFIFO_ext;
        ph   = pop_n_instFIFO_hd;
        acc  = instr_valid && instr_ready;
        word = {instr_src, instr_data};
        if (!pe && !ph) dbl_pop++;
        if ((!pe && ext_q.size() == 0) || (!ph && hd_q.size() == 0)) empty_pop++;
        @(posedge CLK);
        #1;
        if (acc) issued.push_back(word);
        if (!pe && ext_q.size() != 0) void'(ext_q.pop_front());
        if (!ph && hd_q.size() != 0) void'(hd_q.pop_front());
        refresh();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] last_issued();
        if (issued.size() == 0) return 32'hFFFF_FFFF;
        return 32'(issued[issued.size()-1]);
    endfunction

    initial begin
        logic [W:0] rr_exp[6];
        int         n0;

        rst_n       = 1'b0;
        hd_en       = 1'b0;
        halt        = 1'b0;
        instr_ready = 1'b0;
        refresh();
        repeat (2) @(negedge CLK);
        settle();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_data", 32'(instr_data), 32'd0);
        check("rst_src", 32'(instr_src), 32'd0);
        check("rst_pop_ext", 32'(pop_n_instFIFO_ext), 32'd1);
        check("rst_pop_hd", 32'(pop_n_instFIFO_hd), 32'd1);
        check("rst_cnt_ext", 32'(issue_cnt_ext), 32'd0);
        check("rst_cnt_hd", 32'(issue_cnt_hd), 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;

        // Single source: ext only, ready held high.
        ext_q = '{20'h1_0A0A, 20'h2_0B0B};
        instr_ready = 1'b1;
        refresh();
        settle();
        check("single_pop0", 32'(pop_n_instFIFO_ext), 32'd0);
        cycle();
        check("single_valid1", 32'(instr_valid), 32'd1);
        check("single_data1", 32'(instr_data), 32'h1_0A0A);
        check("single_src1", 32'(instr_src), 32'd0);
        check("single_pop1", 32'(pop_n_instFIFO_ext), 32'd0);
        cycle();
        check("single_data2", 32'(instr_data), 32'h2_0B0B);
        check("single_pop2", 32'(pop_n_instFIFO_ext), 32'd1);
        cycle();
        check("single_drain", 32'(instr_valid), 32'd0);
        check("single_cnt", 32'(issue_cnt_ext), 32'd2);

        // Round-robin tie straight after reset: ext first, then alternate.
        do_reset();
        ext_q = '{20'h1_1111, 20'h1_2222, 20'h1_3333};
        hd_q  = '{20'h8_AAAA, 20'h8_BBBB, 20'h8_CCCC};
        hd_en = 1'b1;
        refresh();
        settle();
        check("rr_first_ext", 32'(pop_n_instFIFO_ext), 32'd0);
        check("rr_first_hd", 32'(pop_n_instFIFO_hd), 32'd1);
        rr_exp = '{{1'b0, 20'h1_1111}, {1'b1, 20'h8_AAAA}, {1'b0, 20'h1_2222},
                   {1'b1, 20'h8_BBBB}, {1'b0, 20'h1_3333}, {1'b1, 20'h8_CCCC}};
        n0 = issued.size();
        repeat (7) cycle();
        check("rr_count", 32'(issued.size() - n0), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rr_word%0d", i),
                  (issued.size() > n0 + i) ? 32'(issued[n0+i]) : 32'hFFFF_FFFF, 32'(rr_exp[i]));
        end
        check("rr_cnt_ext", 32'(issue_cnt_ext), 32'd3);
        check("rr_cnt_hd", 32'(issue_cnt_hd), 32'd3);

        // Backpressure: last grant was hd, so the tie goes to ext.
        instr_ready = 1'b0;
        ext_q = '{20'h3_C001, 20'h3_C002};
        hd_q  = '{20'h9_D001};
        refresh();
        settle();
        check("bp_pop_ext", 32'(pop_n_instFIFO_ext), 32'd0);
        cycle();
        check("bp_loaded", 32'({instr_valid, instr_src, instr_data}), 32'({1'b1, 1'b0, 20'h3_C001}));
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("bp_nopop%0d", i), 32'({pop_n_instFIFO_ext, pop_n_instFIFO_hd}), 32'd3);
            cycle();
            check($sformatf("bp_hold%0d", i), 32'({instr_valid, instr_src, instr_data}),
                  32'({1'b1, 1'b0, 20'h3_C001}));
        end
        instr_ready = 1'b1;
        settle();
        check("bp_reload_pops", 32'({pop_n_instFIFO_ext, pop_n_instFIFO_hd}), 32'b10);
        cycle();
        check("bp_accepted", last_issued(), 32'({1'b0, 20'h3_C001}));
        check("bp_reload", 32'({instr_valid, instr_src, instr_data}), 32'({1'b1, 1'b1, 20'h9_D001}));
        cycle();
        check("bp_next", 32'({instr_src, instr_data}), 32'({1'b0, 20'h3_C002}));
        cycle();
        check("bp_drain", 32'(instr_valid), 32'd0);

        // hd_en gating.
        hd_en = 1'b0;
        hd_q  = '{20'hA_E001};
        refresh();
        settle();
        check("hden_nopop", 32'(pop_n_instFIFO_hd), 32'd1);
        cycle();
        check("hden_idle", 32'(instr_valid), 32'd0);
        hd_en = 1'b1;
        instr_ready = 1'b0;
        settle();
        check("hden_pop", 32'(pop_n_instFIFO_hd), 32'd0);
        cycle();
        check("hden_loaded", 32'({instr_valid, instr_src, instr_data}), 32'({1'b1, 1'b1, 20'hA_E001}));

        // halt: held word drains, no new pops.
        halt = 1'b1;
        instr_ready = 1'b1;
        hd_q.push_back(20'hA_E002);
        refresh();
        settle();
        check("halt_nopop0", 32'(pop_n_instFIFO_hd), 32'd1);
        cycle();
        check("halt_drained", 32'(instr_valid), 32'd0);
        check("halt_issued", last_issued(), 32'({1'b1, 20'hA_E001}));
        settle();
        check("halt_nopop1", 32'(pop_n_instFIFO_hd), 32'd1);
        cycle();
        check("halt_idle", 32'(instr_valid), 32'd0);
        halt = 1'b0;
        settle();
        check("unhalt_pop", 32'(pop_n_instFIFO_hd), 32'd0);
        cycle();
        check("unhalt_loaded", 32'({instr_valid, instr_data}), 32'({1'b1, 20'hA_E002}));
        hd_en = 1'b0;
        cycle();
        check("hden_off_issue", last_issued(), 32'({1'b1, 20'hA_E002}));
        check("hden_off_drain", 32'(instr_valid), 32'd0);

        // Saturation of the ext counter.
        force dut.cnt_ext_q = 16'hFFFE;
        #1;
        release dut.cnt_ext_q;
        check("sat_preset", 32'(issue_cnt_ext), 32'h0000_FFFE);
        ext_q = '{20'h5_0001, 20'h5_0002, 20'h5_0003};
        refresh();
        cycle();
        cycle();
        check("sat_ffff", 32'(issue_cnt_ext), 32'h0000_FFFF);
        cycle();
        cycle();
        check("sat_hold", 32'(issue_cnt_ext), 32'h0000_FFFF);
        check("sat_drain", 32'(instr_valid), 32'd0);

        // Async reset between edges while a word is held.
        instr_ready = 1'b0;
        ext_q = '{20'h6_0001, 20'h6_0002};
        hd_q  = '{20'hB_0001};
        refresh();
        cycle();
        check("ar_loaded", 32'({instr_valid, instr_data}), 32'({1'b1, 20'h6_0001}));
        hd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(instr_valid), 32'd0);
        check("ar_pops", 32'({pop_n_instFIFO_ext, pop_n_instFIFO_hd}), 32'd3);
        check("ar_cnt_ext", 32'(issue_cnt_ext), 32'd0);
        check("ar_cnt_hd", 32'(issue_cnt_hd), 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        settle();
        check("ar_tie_pops", 32'({pop_n_instFIFO_ext, pop_n_instFIFO_hd}), 32'b01);
        cycle();
        check("ar_first", 32'({instr_valid, instr_src, instr_data}), 32'({1'b1, 1'b0, 20'h6_0002}));
        cycle();
        check("ar_second", 32'({instr_src, instr_data}), 32'({1'b1, 20'hB_0001}));
        cycle();

        check("never_double_pop", 32'(dbl_pop), 32'd0);
        check("never_pop_empty", 32'(empty_pop), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
